fix_serializer_in_module: RTL and testbench

- Transmit-side counterpart of the FIX tag/value extractor.
- Accepts one tag/value field per handshake, right-aligned ASCII in fixed-width registers.
- Emits the field as an ASCII byte stream "tag=value<SOH>", one byte per cycle under valid/ready backpressure.
- On the last field of a message, appends the FIX trailer "10=CCC<SOH>", where CCC is the mod-256 checksum of every byte of the message before the trailer.
- Sits between the order-building logic and the byte-serial link/MAC interface.

---
 rtl/fix_serializer_in_module_if.sv | 30 +++
 rtl/fix_serializer_in_module.sv | 205 ++++++++++++++++++++
 tb/tb_fix_serializer_in_module.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fix_serializer_in_module_if.sv
// Field-in / byte-out handshake bundle for the FIX serializer.
// The slave side is the serializer; the master side is the field producer and the byte sink.
interface fix_serializer_in_module_if #(
    parameter int unsigned TAG_BYTES   = 4,
    parameter int unsigned VALUE_BYTES = 32
);
    logic                       field_valid_i;
    logic                       field_ready_o;
    logic [8*TAG_BYTES-1:0]     field_tag_i;
    logic [2:0]                 field_tag_len_i;
    logic [8*VALUE_BYTES-1:0]   field_value_i;
    logic [5:0]                 field_value_len_i;
    logic                       field_last_i;
    logic [7:0]                 byte_o;
    logic                       byte_valid_o;
    logic                       byte_ready_i;
    logic                       byte_last_o;

    modport slave (
        input  field_valid_i, field_tag_i, field_tag_len_i, field_value_i,
               field_value_len_i, field_last_i, byte_ready_i,
        output field_ready_o, byte_o, byte_valid_o, byte_last_o
    );

    modport master (
        output field_valid_i, field_tag_i, field_tag_len_i, field_value_i,
               field_value_len_i, field_last_i, byte_ready_i,
        input  field_ready_o, byte_o, byte_valid_o, byte_last_o
    );
endinterface

// File: rtl/fix_serializer_in_module.sv
// Serializes one FIX tag/value field per handshake into "tag=value<SOH>" bytes and
// closes a message with the "10=CCC<SOH>" checksum trailer.
module fix_serializer_in_module #(
    parameter int unsigned TAG_BYTES   = 4,
    parameter int unsigned VALUE_BYTES = 32,
    parameter logic [7:0]  SOH_CHAR    = 8'h01
) (
    input  logic                          clk,
    input  logic                          rst,
    fix_serializer_in_module_if.slave     bus,
    output logic                          err_o,
    output logic                          busy_o
);
    localparam int unsigned TAG_W = 8 * TAG_BYTES;
    localparam int unsigned VAL_W = 8 * VALUE_BYTES;
    localparam int unsigned IDX_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE, ST_TAG, ST_EQ, ST_VAL, ST_SOH, ST_CK_TAG, ST_CK_DIG, ST_CK_SOH
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [VAL_W-1:0]   val_q, val_d;
    logic [IDX_W-1:0]   val_len_q, val_len_d;
    logic               last_q, last_d;
    logic [7:0]         acc_q, acc_d;
    logic [7:0]         ck_q, ck_d;
    logic               err_q, err_d;
    logic [7:0]         byte_q, byte_d;
    logic               byte_valid_q;
    logic               byte_last_q;
    logic               busy_q;
    logic               ready_q;

    logic accept;
    logic xfer;
    logic fld_legal;

    assign accept    = bus.field_valid_i && (state_q == ST_IDLE);
    assign xfer      = byte_valid_q && bus.byte_ready_i;
    assign fld_legal = (bus.field_tag_len_i != 3'd0)
                    && (32'(bus.field_tag_len_i) <= TAG_BYTES)
                    && (bus.field_value_len_i != 6'd0)
                    && (32'(bus.field_value_len_i) <= VALUE_BYTES);

    // Next state, then the byte that state presents; byte_d depends only on *_d so it holds while stalled.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tag_d     = tag_q;
        val_d     = val_q;
        val_len_d = val_len_q;
        last_d    = last_q;
        acc_d     = acc_q;
        ck_d      = ck_q;
        err_d     = 1'b0;
        byte_d    = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tag_d     = bus.field_tag_i;
                    val_d     = bus.field_value_i;
                    val_len_d = bus.field_value_len_i;
                    last_d    = bus.field_last_i;
                    if (fld_legal) begin
                        state_d = ST_TAG;
                        idx_d   = IDX_W'(bus.field_tag_len_i) - IDX_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_TAG: begin
                if (xfer) begin
                    acc_d = acc_q + byte_q;
                    if (idx_q == '0) state_d = ST_EQ;
                    else             idx_d   = idx_q - IDX_W'(1);
                end
            end
            ST_EQ: begin
                if (xfer) begin
                    acc_d   = acc_q + byte_q;
                    state_d = ST_VAL;
                    idx_d   = val_len_q - IDX_W'(1);
                end
            end
            ST_VAL: begin
                if (xfer) begin
                    acc_d = acc_q + byte_q;
                    if (idx_q == '0) state_d = ST_SOH;
                    else             idx_d   = idx_q - IDX_W'(1);
                end
            end
            ST_SOH: begin
                if (xfer) begin
                    acc_d = acc_q + byte_q;
                    if (last_q) begin
                        state_d = ST_CK_TAG;
                        idx_d   = IDX_W'(2);
                        ck_d    = acc_q + byte_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CK_TAG: begin
                if (xfer) begin
                    if (idx_q == '0) begin
                        state_d = ST_CK_DIG;
                        idx_d   = IDX_W'(2);
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end
            ST_CK_DIG: begin
                if (xfer) begin
                    if (idx_q == '0) state_d = ST_CK_SOH;
                    else             idx_d   = idx_q - IDX_W'(1);
                end
            end
            ST_CK_SOH: begin
                if (xfer) begin
                    acc_d   = 8'h00;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_TAG: begin
                for (int unsigned k = 0; k < TAG_BYTES; k++) begin
                    if (idx_d == IDX_W'(k)) byte_d = tag_d[8*k +: 8];
                end
            end
            ST_EQ:  byte_d = 8'h3D;
            ST_VAL: begin
                for (int unsigned k = 0; k < VALUE_BYTES; k++) begin
                    if (idx_d == IDX_W'(k)) byte_d = val_d[8*k +: 8];
                end
            end
            ST_SOH, ST_CK_SOH: byte_d = SOH_CHAR;
            ST_CK_TAG: begin
                case (idx_d)
                    IDX_W'(2): byte_d = 8'h31;
                    IDX_W'(1): byte_d = 8'h30;
                    default:   byte_d = 8'h3D;
                endcase
            end
            ST_CK_DIG: begin
                case (idx_d)
                    IDX_W'(2): byte_d = 8'h30 + (ck_d / 8'd100);
                    IDX_W'(1): byte_d = 8'h30 + ((ck_d / 8'd10) % 8'd10);
                    default:   byte_d = 8'h30 + (ck_d % 8'd10);
                endcase
            end
            default: byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            tag_q        <= '0;
            val_q        <= '0;
            val_len_q    <= '0;
            last_q       <= 1'b0;
            acc_q        <= 8'h00;
            ck_q         <= 8'h00;
            err_q        <= 1'b0;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            byte_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tag_q        <= tag_d;
            val_q        <= val_d;
            val_len_q    <= val_len_d;
            last_q       <= last_d;
            acc_q        <= acc_d;
            ck_q         <= ck_d;
            err_q        <= err_d;
            byte_q       <= byte_d;
            byte_valid_q <= (state_d != ST_IDLE);
            byte_last_q  <= (state_d == ST_CK_SOH);
            busy_q       <= (state_d != ST_IDLE);
            ready_q      <= (state_d == ST_IDLE);
        end
    end

    assign bus.field_ready_o = ready_q;
    assign bus.byte_o        = byte_q;
    assign bus.byte_valid_o  = byte_valid_q;
    assign bus.byte_last_o   = byte_last_q;
    assign err_o             = err_q;
    assign busy_o            = busy_q;
endmodule

// File: tb/tb_fix_serializer_in_module.sv
// Directed bench for the FIX field serializer: byte streams, checksum trailer,
// backpressure, illegal fields and mid-message reset.
module tb_fix_serializer_in_module;
    localparam int unsigned TAG_BYTES   = 4;
    localparam int unsigned VALUE_BYTES = 32;

    logic clk = 1'b0;
    logic rst;
    logic err;
    logic busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rx_q[$];
    logic       rx_last_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] tb_acc;

    fix_serializer_in_module_if #(.TAG_BYTES(TAG_BYTES), .VALUE_BYTES(VALUE_BYTES)) bus ();

    fix_serializer_in_module #(
        .TAG_BYTES  (TAG_BYTES),
        .VALUE_BYTES(VALUE_BYTES),
        .SOH_CHAR   (8'h01)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .err_o  (err),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so a handshake seen at negedge completes at the next posedge.
    always @(negedge clk) begin
        if (!rst && bus.byte_valid_o && bus.byte_ready_i) begin
            rx_q.push_back(bus.byte_o);
            rx_last_q.push_back(bus.byte_last_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] b);
        exp_q.push_back(b);
        tb_acc = tb_acc + b;
    endtask

    task automatic model(input logic [31:0] tag, input int tlen,
                         input logic [255:0] val, input int vlen, input bit last);
        for (int k = tlen - 1; k >= 0; k--) push_exp(tag[8*k +: 8]);
        push_exp(8'h3D);
        for (int k = vlen - 1; k >= 0; k--) push_exp(val[8*k +: 8]);
        push_exp(8'h01);
        if (last) begin
            exp_q.push_back(8'h31);
            exp_q.push_back(8'h30);
            exp_q.push_back(8'h3D);
            exp_q.push_back(8'h30 + tb_acc / 8'd100);
            exp_q.push_back(8'h30 + (tb_acc / 8'd10) % 8'd10);
            exp_q.push_back(8'h30 + tb_acc % 8'd10);
            exp_q.push_back(8'h01);
            tb_acc = 8'h00;
        end
    endtask

    task automatic send_field(input string name, input logic [31:0] tag, input int tlen,
                              input logic [255:0] val, input int vlen,
                              input bit last, input bit legal);
        bit ok;
        logic [7:0] first;
        ok = 1'b0;
        bus.field_tag_i       = tag;
        bus.field_tag_len_i   = 3'(tlen);
        bus.field_value_i     = val;
        bus.field_value_len_i = 6'(vlen);
        bus.field_last_i      = last;
        bus.field_valid_i     = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            ok = bus.field_ready_o;
            tick();
        end
        bus.field_valid_i = 1'b0;
        bus.field_tag_i   = 32'hDEADBEEF;
        bus.field_value_i = '1;
        chk({name, "_accept"}, 32'(ok), 32'd1);
        if (legal && tlen > 0) begin
            first = tag[8*(tlen-1) +: 8];
            chk({name, "_lat_valid"}, 32'(bus.byte_valid_o), 32'd1);
            chk({name, "_lat_byte"}, 32'(bus.byte_o), 32'(first));
        end
    endtask

    task automatic wait_bytes(input string name, input int n, input int budget);
        int i;
        i = 0;
        while (rx_q.size() < n && i < budget) begin
            tick();
            i++;
        end
        chk({name, "_bytes_arrived"}, 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic cmp_stream(input string name, input bit has_trailer);
        chk({name, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk($sformatf("%s_b%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
            chk($sformatf("%s_last%0d", name, i), 32'(rx_last_q[i]),
                32'(has_trailer && (i == exp_q.size() - 1)));
        end
    endtask

    task automatic clear_streams();
        rx_q.delete();
        rx_last_q.delete();
        exp_q.delete();
    endtask

    task automatic stall3(input string name);
        logic [7:0] hold;
        logic       hold_last;
        bus.byte_ready_i = 1'b0;
        hold      = bus.byte_o;
        hold_last = bus.byte_last_o;
        chk({name, "_held_exp"}, 32'(hold), 32'(exp_q[rx_q.size()]));
        repeat (3) begin
            tick();
            chk({name, "_stable_byte"}, 32'(bus.byte_o), 32'(hold));
            chk({name, "_stable_last"}, 32'(bus.byte_last_o), 32'(hold_last));
            chk({name, "_stable_valid"}, 32'(bus.byte_valid_o), 32'd1);
        end
        bus.byte_ready_i = 1'b1;
    endtask

    localparam logic [255:0] VAL_A   = 256'h41;
    localparam logic [255:0] VAL_FIX = 256'h4649582E342E32;
    localparam logic [255:0] VAL_32  =
        256'h4142434445464748494A4B4C4D4E4F505152535455565758595A303132333435;

    initial begin
        bit s1;
        bit s2;
        int guard;

        rst                   = 1'b1;
        tb_acc                = 8'h00;
        bus.field_valid_i     = 1'b0;
        bus.field_tag_i       = '0;
        bus.field_tag_len_i   = '0;
        bus.field_value_i     = '0;
        bus.field_value_len_i = '0;
        bus.field_last_i      = 1'b0;
        bus.byte_ready_i      = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_byte", 32'(bus.byte_o), 32'h0);
        chk("rst_valid", 32'(bus.byte_valid_o), 32'd0);
        chk("rst_last", 32'(bus.byte_last_o), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(bus.field_ready_o), 32'd1);
        rst = 1'b0;
        tick();

        // 35=A| 10=231|
        clear_streams();
        model(32'h3335, 2, VAL_A, 1, 1'b1);
        send_field("t1", 32'h3335, 2, VAL_A, 1, 1'b1, 1'b1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ready_low", 32'(bus.field_ready_o), 32'd0);
        wait_bytes("t1", 12, 100);
        repeat (4) tick();
        cmp_stream("t1", 1'b1);
        chk("t1_ck_h", 32'(rx_q[8]), 32'h32);
        chk("t1_ck_t", 32'(rx_q[9]), 32'h33);
        chk("t1_ck_u", 32'(rx_q[10]), 32'h31);
        chk("t1_idle_valid", 32'(bus.byte_valid_o), 32'd0);

        // 8=FIX.4.2| sums to 543 -> 031
        clear_streams();
        model(32'h38, 1, VAL_FIX, 7, 1'b1);
        send_field("t2", 32'h38, 1, VAL_FIX, 7, 1'b1, 1'b1);
        wait_bytes("t2", 17, 100);
        repeat (4) tick();
        cmp_stream("t2", 1'b1);
        chk("t2_ck_h", 32'(rx_q[13]), 32'h30);
        chk("t2_ck_t", 32'(rx_q[14]), 32'h33);
        chk("t2_ck_u", 32'(rx_q[15]), 32'h31);

        // Full-width tag and value, not last: 38 bytes, no trailer
        clear_streams();
        model(32'h39393939, 4, VAL_32, 32, 1'b0);
        send_field("t3", 32'h39393939, 4, VAL_32, 32, 1'b0, 1'b1);
        wait_bytes("t3", 38, 100);
        chk("t3_ready_back", 32'(bus.field_ready_o), 32'd1);
        chk("t3_busy_low", 32'(busy), 32'd0);
        repeat (4) tick();
        cmp_stream("t3", 1'b0);
        chk("t3_first", 32'(rx_q[0]), 32'h39);
        chk("t3_val0", 32'(rx_q[5]), 32'h41);
        chk("t3_soh", 32'(rx_q[37]), 32'h01);

        // Close that message with a second field; checksum spans both fields
        clear_streams();
        model(32'h3335, 2, VAL_A, 1, 1'b1);
        send_field("t3b", 32'h3335, 2, VAL_A, 1, 1'b1, 1'b1);
        wait_bytes("t3b", 12, 100);
        repeat (4) tick();
        cmp_stream("t3b", 1'b1);

        // Same as t2 with stalls in VAL and CK_DIG
        clear_streams();
        model(32'h38, 1, VAL_FIX, 7, 1'b1);
        send_field("t4", 32'h38, 1, VAL_FIX, 7, 1'b1, 1'b1);
        s1 = 1'b0;
        s2 = 1'b0;
        guard = 0;
        while (rx_q.size() < 17 && guard < 200) begin
            if (rx_q.size() == 4 && !s1) begin
                stall3("t4_val");
                s1 = 1'b1;
            end else if (rx_q.size() == 14 && !s2) begin
                stall3("t4_dig");
                s2 = 1'b1;
            end
            tick();
            guard++;
        end
        chk("t4_stalls_hit", 32'({s1, s2}), 32'd3);
        chk("t4_bytes_arrived", 32'(rx_q.size() >= 17), 32'd1);
        repeat (4) tick();
        cmp_stream("t4", 1'b1);

        // Illegal tag_len 0 then legal last field
        clear_streams();
        send_field("t5", 32'h3335, 0, VAL_A, 1, 1'b1, 1'b0);
        chk("t5_err_pulse", 32'(err), 32'd1);
        chk("t5_no_valid", 32'(bus.byte_valid_o), 32'd0);
        chk("t5_ready", 32'(bus.field_ready_o), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        tick();
        chk("t5_err_clear", 32'(err), 32'd0);
        send_field("t5v", 32'h3335, 2, VAL_A, 33, 1'b0, 1'b0);
        chk("t5v_err_pulse", 32'(err), 32'd1);
        repeat (3) tick();
        chk("t5_no_bytes", 32'(rx_q.size()), 32'd0);
        model(32'h3335, 2, VAL_A, 1, 1'b1);
        send_field("t5b", 32'h3335, 2, VAL_A, 1, 1'b1, 1'b1);
        wait_bytes("t5b", 12, 100);
        repeat (4) tick();
        cmp_stream("t5b", 1'b1);
        chk("t5_ck_t", 32'(rx_q[9]), 32'h33);

        // Reset in VAL abandons the message and clears the accumulator
        clear_streams();
        send_field("t6", 32'h3335, 2, VAL_FIX, 7, 1'b1, 1'b1);
        wait_bytes("t6", 4, 50);
        rst = 1'b1;
        tick();
        tick();
        chk("t6_rst_valid", 32'(bus.byte_valid_o), 32'd0);
        chk("t6_rst_byte", 32'(bus.byte_o), 32'h0);
        chk("t6_rst_last", 32'(bus.byte_last_o), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_ready", 32'(bus.field_ready_o), 32'd1);
        rst = 1'b0;
        tick();
        clear_streams();
        tb_acc = 8'h00;
        model(32'h3335, 2, VAL_A, 1, 1'b1);
        send_field("t6b", 32'h3335, 2, VAL_A, 1, 1'b1, 1'b1);
        wait_bytes("t6b", 12, 100);
        repeat (4) tick();
        cmp_stream("t6b", 1'b1);
        chk("t6_ck_h", 32'(rx_q[8]), 32'h32);
        chk("t6_ck_u", 32'(rx_q[10]), 32'h31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
